// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with programmable modulus, parallel load,
// synchronous clear, wrap/saturate limit handling and a sticky overflow flag.
module mod_updown_counter #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be in 2..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("mod_updown_counter: MODULUS must be in 2..2**WIDTH");
  end

  // Out-of-range load values are pinned to the top of the count range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX) ? MAX : v;
  endfunction

  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             ovf_nxt;

  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    ovf_nxt  = ovf;
    if (clear) begin
      q_nxt   = ZERO;
      ovf_nxt = 1'b0;
    end else if (load) begin
      q_nxt = clamp_load(d);
    end else if (en) begin
      if (up) begin
        if (q == MAX) begin
          wrap_nxt = 1'b1;
          q_nxt    = SATURATE ? q : ZERO;
        end else begin
          q_nxt = q + ONE;
        end
      end else begin
        if (q == ZERO) begin
          wrap_nxt = 1'b1;
          q_nxt    = SATURATE ? q : MAX;
        end else begin
          q_nxt = q - ONE;
        end
      end
      ovf_nxt = ovf | wrap_nxt;
    end
  end

  // tc looks at the current count only, so a cascaded stage sees it this cycle.
  assign tc = en & ((up & (q == MAX)) | (~up & (q == ZERO)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= ZERO;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
      ovf  <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench: three counter configurations share one stimulus stream and
// are compared against an arithmetic model of the counting rules.
module tb_mod_updown_counter;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       en    = 1'b0;
  logic       up    = 1'b1;
  logic       load  = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] d     = '0;

  logic [3:0] qv [3];
  logic       tcv [3];
  logic       wv [3];
  logic       ov [3];

  int checks = 0;
  int errors = 0;

  int modv [3] = '{10, 10, 16};
  int satv [3] = '{0, 1, 0};
  int mq [3]   = '{0, 0, 0};
  int mo [3]   = '{0, 0, 0};

  typedef struct packed {
    logic [3:0] q;
    logic       w;
    logic       o;
  } e_t;
  typedef e_t [2:0] trio_t;
  trio_t sb [$];

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_w10 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .d(d), .clear(clear),
    .q(qv[0]), .tc(tcv[0]), .wrap(wv[0]), .ovf(ov[0]));
  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_s10 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .d(d), .clear(clear),
    .q(qv[1]), .tc(tcv[1]), .wrap(wv[1]), .ovf(ov[1]));
  mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_w16 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .d(d), .clear(clear),
    .q(qv[2]), .tc(tcv[2]), .wrap(wv[2]), .ovf(ov[2]));

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endfunction

  // Drive one cycle of inputs, check tc, push the expected post-edge state.
  task automatic step(input bit c, input bit l, input bit e, input bit u, input int dv);
    trio_t t;
    int m, nq, nw, no;
    @(negedge clk);
    clear = c; load = l; en = e; up = u; d = 4'(dv);
    #1;
    for (int i = 0; i < 3; i++) begin
      m = modv[i];
      check($sformatf("tc[%0d]", i), int'(tcv[i]),
            (e && ((u && mq[i] == m - 1) || (!u && mq[i] == 0))) ? 1 : 0);
      nq = mq[i]; nw = 0; no = mo[i];
      if (c) begin
        nq = 0; no = 0;
      end else if (l) begin
        nq = (dv > m - 1) ? m - 1 : dv;
      end else if (e) begin
        if (u) begin
          nw = (mq[i] + 1 >= m) ? 1 : 0;
          nq = (satv[i] != 0) ? ((mq[i] + 1 > m - 1) ? m - 1 : mq[i] + 1) : (mq[i] + 1) % m;
        end else begin
          nw = (mq[i] - 1 < 0) ? 1 : 0;
          nq = (satv[i] != 0) ? ((mq[i] - 1 < 0) ? 0 : mq[i] - 1) : (mq[i] - 1 + m) % m;
        end
        no = (mo[i] != 0 || nw != 0) ? 1 : 0;
      end
      t[i].q = 4'(nq);
      t[i].w = nw[0];
      t[i].o = no[0];
      mq[i] = nq;
      mo[i] = no;
    end
    sb.push_back(t);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic async_reset();
    @(negedge clk);
    clear = 1'b0; load = 1'b0; en = 1'b0;
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("async_rst_q[%0d]", i), int'(qv[i]), 0);
      check($sformatf("async_rst_wrap[%0d]", i), int'(wv[i]), 0);
      check($sformatf("async_rst_ovf[%0d]", i), int'(ov[i]), 0);
      mq[i] = 0; mo[i] = 0;
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      trio_t t;
      t = sb.pop_front();
      for (int i = 0; i < 3; i++) begin
        check($sformatf("q[%0d]", i), int'(qv[i]), int'(t[i].q));
        check($sformatf("wrap[%0d]", i), int'(wv[i]), int'(t[i].w));
        check($sformatf("ovf[%0d]", i), int'(ov[i]), int'(t[i].o));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_q[%0d]", i), int'(qv[i]), 0);
      check($sformatf("reset_wrap[%0d]", i), int'(wv[i]), 0);
      check($sformatf("reset_ovf[%0d]", i), int'(ov[i]), 0);
    end
    @(negedge clk);
    reset = 1'b1;

    repeat (12) step(0, 0, 1, 1, 0);
    settle();
    check("w10_q_after_12_up", int'(qv[0]), 2);
    check("w10_ovf_after_wrap", int'(ov[0]), 1);

    step(1, 0, 0, 1, 0);
    repeat (3) step(0, 0, 1, 0, 0);
    settle();
    check("w10_q_after_3_down", int'(qv[0]), 7);

    step(0, 1, 0, 1, 8);
    repeat (4) step(0, 0, 1, 1, 0);
    repeat (2) step(0, 0, 1, 0, 0);
    settle();
    check("s10_q_after_sat_then_down", int'(qv[1]), 7);
    check("s10_ovf_after_sat", int'(ov[1]), 1);

    step(0, 1, 0, 1, 13);
    settle();
    check("w10_load_clamp", int'(qv[0]), 9);
    check("w16_load_13", int'(qv[2]), 13);
    step(0, 1, 1, 1, 4);
    settle();
    check("w10_load_beats_en", int'(qv[0]), 4);
    step(1, 1, 1, 1, 7);
    settle();
    check("w10_clear_beats_load_q", int'(qv[0]), 0);
    check("w10_clear_beats_load_ovf", int'(ov[0]), 0);

    step(0, 1, 0, 1, 9);
    step(0, 0, 1, 1, 0);
    step(0, 1, 0, 1, 4);
    step(0, 0, 1, 1, 0);
    settle();
    check("w10_q_before_async", int'(qv[0]), 5);
    check("w10_ovf_before_async", int'(ov[0]), 1);
    async_reset();
    step(0, 0, 1, 1, 0);
    settle();
    for (int i = 0; i < 3; i++) check($sformatf("first_count_after_reset[%0d]", i), int'(qv[i]), 1);

    step(1, 0, 0, 1, 0);
    repeat (20) step(0, 0, 1, 1, 0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 149) == 0) async_reset();
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
    end
    settle();
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
